// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: per-source pending bits, software mask,
// lowest-index priority, and a single in-service source held until EOI.
module int_ctrl #(
    parameter int unsigned N_SRC = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:2]       addr,
    input  logic             We,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] IrqIn,
    input  logic             IntAck,
    output logic             IntReq
);

    localparam int unsigned ID_W = 3;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             state;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   edge_en;
    logic [N_SRC-1:0]   pend_edge;
    logic [N_SRC-1:0]   irq_q;
    logic [ID_W-1:0]    is_id;
    logic               is_valid;

    logic [N_SRC-1:0]   pend;
    logic [N_SRC-1:0]   active;
    logic [N_SRC-1:0]   is_sel;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   edge_set;
    logic [N_SRC-1:0]   pend_edge_nxt;
    logic [ID_W-1:0]    winner;
    logic               id_active;
    logic               ack_hit;
    logic               eoi;

    // Level sources mirror the sampled line; edge sources use the sticky latch.
    always_comb begin
        pend          = (edge_en & pend_edge) | (~edge_en & irq_q);
        active        = pend & mask;
        ack_hit       = (state == S_REQ) && IntAck;
        eoi           = We && (addr == REG_VEC);
        w1c           = (We && (addr == REG_PEND)) ? (Din[N_SRC-1:0] & edge_en) : '0;
        edge_set      = edge_en & IrqIn & ~irq_q;
        ack_clr       = ack_hit ? (is_sel & edge_en) : '0;
        pend_edge_nxt = edge_set | (pend_edge & ~(w1c | ack_clr));
        id_active     = |(active & is_sel);
    end

    // Lowest active index wins; one-hot decode of the latched in-service id.
    always_comb begin
        winner = '0;
        is_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            is_sel[i] = (is_id == ID_W'(i));
        end
    end

    always_comb begin
        Dout = '0;
        case (addr)
            REG_MASK: Dout = 32'(mask);
            REG_PEND: Dout = 32'(pend);
            REG_VEC:  Dout = {is_valid, 28'b0, is_id};
            REG_EDGE: Dout = 32'(edge_en);
            default:  Dout = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask      <= '0;
            edge_en   <= '0;
            pend_edge <= '0;
            irq_q     <= '0;
        end else begin
            irq_q     <= IrqIn;
            pend_edge <= pend_edge_nxt;
            if (We && (addr == REG_MASK)) mask    <= Din[N_SRC-1:0];
            if (We && (addr == REG_EDGE)) edge_en <= Din[N_SRC-1:0];
        end
    end

    // Request/service sequencing; IntReq is high exactly while in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            is_id    <= '0;
            is_valid <= 1'b0;
            IntReq   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|active) begin
                        is_id  <= winner;
                        state  <= S_REQ;
                        IntReq <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (IntAck) begin
                        state    <= S_SERVICE;
                        is_valid <= 1'b1;
                        IntReq   <= 1'b0;
                    end else if (!id_active) begin
                        state  <= S_IDLE;
                        IntReq <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (eoi) begin
                        is_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    IntReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;

    localparam int unsigned N = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    addr;
    logic          We;
    logic [31:0]   Din;
    logic [31:0]   Dout;
    logic [N-1:0]  IrqIn;
    logic          IntAck;
    logic          IntReq;

    int n_vec = 0;
    int n_err = 0;

    int_ctrl #(.N_SRC(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .We     (We),
        .Din    (Din),
        .Dout   (Dout),
        .IrqIn  (IrqIn),
        .IntAck (IntAck),
        .IntReq (IntReq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = requesting, 2 = in service.
    bit [N-1:0] m_mask, m_edge, m_pe, m_q;
    int         m_st;
    int         m_id;
    bit         m_valid;
    bit         m_id_known;

    function automatic bit [N-1:0] m_pend();
        bit [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_edge[i] ? m_pe[i] : m_q[i];
        return r;
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_pend());
            2'd2:    return {m_valid, 28'b0, 3'(m_id)};
            default: return 32'(m_edge);
        endcase
    endfunction

    task automatic m_step();
        bit [N-1:0] act;
        bit [N-1:0] new_pe;
        int         first;
        bit         rise, clr;
        if (rst) begin
            m_mask = '0; m_edge = '0; m_pe = '0; m_q = '0;
            m_st = 0; m_id = 0; m_valid = 0; m_id_known = 1;
            return;
        end
        act   = m_pend() & m_mask;
        first = -1;
        for (int i = 0; i < N; i++) if (act[i] && first < 0) first = i;
        new_pe = m_pe;
        for (int i = 0; i < N; i++) begin
            rise = m_edge[i] && IrqIn[i] && !m_q[i];
            clr  = m_edge[i] && ((We && addr == 2'd1 && Din[i]) || (m_st == 1 && IntAck && m_id == i));
            if (rise) new_pe[i] = 1'b1;
            else if (clr) new_pe[i] = 1'b0;
        end
        case (m_st)
            0: if (first >= 0) begin m_id = first; m_id_known = 1; m_st = 1; end
            1: if (IntAck) begin m_st = 2; m_valid = 1; end
               else if (!act[m_id]) begin m_st = 0; m_id_known = 0; end
            default: if (We && addr == 2'd2) begin m_valid = 0; m_st = 0; end
        endcase
        m_pe = new_pe;
        if (We && addr == 2'd0) m_mask = Din[N-1:0];
        if (We && addr == 2'd3) m_edge = Din[N-1:0];
        m_q = IrqIn;
    endtask

    // Per-cycle compare against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        m_step();
        #1;
        chk("model_int_req", 32'(IntReq), 32'(m_st == 1));
        if (addr == 2'd2 && !m_id_known)
            chk("model_vec_hi", Dout & 32'hFFFF_FFF8, m_dout(addr) & 32'hFFFF_FFF8);
        else
            chk("model_dout", Dout, m_dout(addr));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; Din = d; We = 1'b1;
        tick();
        We = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic ack();
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
    endtask

    task automatic do_reset();
        IrqIn = '0; We = 1'b0; IntAck = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 2'd0; We = 1'b0; Din = '0; IrqIn = '0; IntAck = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_int_req", 32'(IntReq), 32'd0);
        rd("reset_mask", 2'd0, 32'h0);
        rd("reset_pend", 2'd1, 32'h0);
        rd("reset_vec",  2'd2, 32'h0);
        rd("reset_edge", 2'd3, 32'h0);

        // Level, single source
        do_reset();
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h00);
        IrqIn = 6'b000001;
        tick();
        chk("lvl_req_1cyc", 32'(IntReq), 32'd0);
        tick();
        chk("lvl_req_2cyc", 32'(IntReq), 32'd1);
        ack();
        chk("lvl_ack_req", 32'(IntReq), 32'd0);
        rd("lvl_vec", 2'd2, 32'h8000_0000);
        IrqIn = '0;
        wr(2'd2, 32'h0);
        chk("lvl_eoi_req", 32'(IntReq), 32'd0);
        tick();
        chk("lvl_idle_req", 32'(IntReq), 32'd0);
        rd("lvl_vec_eoi", 2'd2, 32'h0);

        // Priority
        do_reset();
        wr(2'd0, 32'h3F);
        IrqIn = 6'b100100;
        tick();
        tick();
        chk("prio_req", 32'(IntReq), 32'd1);
        ack();
        rd("prio_vec2", 2'd2, 32'h8000_0002);
        IrqIn = 6'b100000;
        wr(2'd2, 32'h0);
        tick();
        chk("prio_rereq", 32'(IntReq), 32'd1);
        ack();
        rd("prio_vec5", 2'd2, 32'h8000_0005);
        IrqIn = '0;
        wr(2'd2, 32'h0);

        // Edge latch
        do_reset();
        wr(2'd3, 32'h02);
        IrqIn = 6'b000010;
        tick();
        IrqIn = '0;
        rd("edge_pend", 2'd1, 32'h02);
        wr(2'd0, 32'h02);
        tick();
        chk("edge_req", 32'(IntReq), 32'd1);
        ack();
        rd("edge_pend_ack", 2'd1, 32'h00);
        rd("edge_vec", 2'd2, 32'h8000_0001);
        wr(2'd2, 32'h0);

        // Withdrawal, then ack racing the mask write
        do_reset();
        IrqIn = 6'b001000;
        wr(2'd0, 32'h08);
        tick();
        chk("wd_req", 32'(IntReq), 32'd1);
        wr(2'd0, 32'h00);
        chk("wd_still_req", 32'(IntReq), 32'd1);
        tick();
        chk("wd_dropped", 32'(IntReq), 32'd0);
        wr(2'd0, 32'h08);
        tick();
        chk("wd2_req", 32'(IntReq), 32'd1);
        addr = 2'd0; Din = 32'h0; We = 1'b1; IntAck = 1'b1;
        tick();
        We = 1'b0; IntAck = 1'b0;
        chk("wd2_ack_req", 32'(IntReq), 32'd0);
        rd("wd2_vec", 2'd2, 32'h8000_0003);
        IrqIn = '0;
        wr(2'd2, 32'h0);

        // W1C colliding with a new rising edge
        do_reset();
        wr(2'd3, 32'h01);
        IrqIn = 6'b000001;
        tick();
        IrqIn = '0;
        tick();
        rd("col_pend_pre", 2'd1, 32'h01);
        IrqIn = 6'b000001;
        addr = 2'd1; Din = 32'h01; We = 1'b1;
        tick();
        We = 1'b0;
        rd("col_pend", 2'd1, 32'h01);
        IrqIn = '0;
        tick();
        wr(2'd1, 32'h01);
        rd("w1c_pend", 2'd1, 32'h00);

        // Asynchronous reset while in service
        do_reset();
        wr(2'd0, 32'h01);
        IrqIn = 6'b000001;
        tick();
        tick();
        ack();
        rd("ar_vec_pre", 2'd2, 32'h8000_0000);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_int_req", 32'(IntReq), 32'd0);
        rd("ar_vec", 2'd2, 32'h0);
        rd("ar_mask", 2'd0, 32'h0);
        IrqIn = '0;
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) IrqIn = IrqIn ^ N'($urandom);
            IntAck = ($urandom_range(0, 3) == 0);
            We     = ($urandom_range(0, 4) == 0);
            addr   = 2'($urandom);
            Din    = $urandom;
            rst    = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; We = 1'b0; IntAck = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
